perip_pwm_multi: RTL and testbench
==================================

PERIP_PWM_MULTI -- requirements
Module: perip_pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of PWM channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the counter, period and duty registers, legal range 8..24.
REQ-003 SHALL have parameter PERIOD_RST, default 1000: reset value of PERIOD.
REQ-004 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: d_in  in  32  write data; register bits are taken LSB-aligned.
REQ-007 SHALL have port: cs  in  1  peripheral select.
REQ-008 SHALL have port: addr  in  32  register select; only addr[4:0] is decoded.
REQ-009 SHALL have port: rd  in  1  read strobe, qualified by cs.
REQ-010 SHALL have port: wr  in  1  write strobe, qualified by cs.
REQ-011 SHALL have port: d_out  out  32  registered read data.
REQ-012 SHALL have port: pwm  out  N_CH  registered PWM outputs.

Function
REQ-013 SHALL use this register map on addr[4:0]: 0x00 CTRL (bits [N_CH-1:0] channel enables); 0x01 PERIOD; 0x02 STATUS (bit0 wrap flag); 0x03 FADE_STEP; 0x04+i DUTY[i] for i < N_CH.
REQ-014 SHALL accept a write on the clk edge where cs&&wr; writes to unmapped or unused DUTY addresses SHALL be ignored.
REQ-015 SHALL register read data: the cycle after cs&&rd, d_out holds the selected register, zero-extended.
REQ-016 SHALL return 0 on reads of unmapped addresses, and SHALL hold d_out when no read is issued.
REQ-017 SHALL read back PERIOD and DUTY[i] as the pending (last written) values, not the active ones.
REQ-018 SHALL run a counter cnt from 0 to act_period-1, then wrap to 0, every cycle.
REQ-019 SHALL hold cnt at 0 and drive all pwm low while act_period==0.
REQ-020 SHALL load act_period from pending PERIOD on the wrap cycle (cnt==act_period-1); writes never take effect mid-period.
REQ-021 SHALL load the active duty act_duty[i] on the wrap cycle as well (see REQ-030).
REQ-022 SHALL compute pwm[i] = CTRL[i] && (cnt < act_duty[i]), registered, giving one cycle of latency from cnt.
REQ-023 SHALL hold pwm[i] low for the whole period when act_duty[i]==0.
REQ-024 SHALL hold pwm[i] constantly high when act_duty[i] >= act_period (with act_period != 0).
REQ-025 SHALL force pwm[i] low on the next edge when CTRL[i] is cleared, without waiting for the wrap.
REQ-026 SHALL set STATUS bit0 on every wrap; a read of STATUS clears it; if a set and the clear coincide, set wins.
REQ-027 SHALL load pending PERIOD immediately when it is written while act_period==0, so the block can leave the idle state of REQ-019.

Reset
REQ-028 SHALL on reset set: CTRL=0, pending and active PERIOD=PERIOD_RST, all DUTY and act_duty=0, FADE_STEP=0, cnt=0, STATUS=0, pwm=0, d_out=0.
REQ-029 SHALL on reset mid-period abandon the period; counting restarts at cnt=0 on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with macro PERIP_PWM_FADE_EN defined, move each act_duty[i] toward its pending DUTY[i] by at most FADE_STEP per wrap (saturating, never overshooting); FADE_STEP=0 means immediate load.
REQ-031 SHALL, without PERIP_PWM_FADE_EN, load act_duty[i] directly from DUTY[i] at each wrap; FADE_STEP then reads 0 and writes to it are ignored.

Verification
REQ-032 SHALL cover: reset, PERIOD=10, DUTY[0]=3, CTRL=1 -> after the next wrap, pwm[0] high for 3 cycles and low for 7, repeating.
REQ-033 SHALL cover: DUTY[1]=0 and DUTY[2]=15 with PERIOD=10, CTRL=0x6 -> pwm[1] constant low, pwm[2] constant high.
REQ-034 SHALL cover: DUTY[0] written 3 -> 8 at cnt=5 -> the current period keeps 3 high cycles, and the following period has 8.
REQ-035 SHALL cover: read STATUS after a wrap -> d_out=1 the next cycle; an immediate re-read with no wrap in between -> 0.
REQ-036 SHALL cover: with FADE_EN, FADE_STEP=2, DUTY[0] 0 -> 5 -> act_duty goes 2, 4, 5 on successive wraps.
REQ-037 SHALL cover: reset asserted at cnt=6 -> pwm=0 and d_out=0, then cnt restarts at 0 with PERIOD=PERIOD_RST.

Source files
------------

// File: rtl/perip_pwm_multi.sv
// -----------------------------------------------------------------------------
// perip_pwm_multi
//   Multi-channel PWM peripheral with a small register interface.
//   One shared period counter drives N_CH compare channels. PERIOD and DUTY
//   writes land in pending registers. The active copies reload only at the
//   end of a period, so a period that has started always finishes as set up.
//
// Optional feature macro: PERIP_PWM_FADE_EN
//   When defined, each active duty slews toward its pending value by at most
//   FADE_STEP per period. When undefined, FADE_STEP reads 0, writes to it are
//   ignored, and duties load directly.
//
// Register map (addr[4:0]):
//   0x00 CTRL      [N_CH-1:0] channel enables
//   0x01 PERIOD    pending period (reads back the pending value)
//   0x02 STATUS    bit0 wrap flag, cleared by a read, a new wrap wins
//   0x03 FADE_STEP duty slew per period (fade builds only)
//   0x04+i DUTY[i] pending duty of channel i (reads back the pending value)
//
// Ports:
//   clk    in   1     rising-edge clock
//   reset  in   1     synchronous active-high reset
//   d_in   in   32    write data, register bits taken LSB-aligned
//   cs     in   1     peripheral select
//   addr   in   32    register select, only addr[4:0] decoded
//   rd     in   1     read strobe (qualified by cs)
//   wr     in   1     write strobe (qualified by cs)
//   d_out  out  32    registered read data, held between reads
//   pwm    out  N_CH  registered PWM outputs
// -----------------------------------------------------------------------------
module perip_pwm_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int PERIOD_RST = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     d_in,
    input  logic            cs,
    input  logic [31:0]     addr,
    input  logic            rd,
    input  logic            wr,
    output logic [31:0]     d_out,
    output logic [N_CH-1:0] pwm
);

    localparam logic [4:0]       ADDR_CTRL    = 5'h00;
    localparam logic [4:0]       ADDR_PERIOD  = 5'h01;
    localparam logic [4:0]       ADDR_STATUS  = 5'h02;
    localparam logic [4:0]       ADDR_FADE    = 5'h03;
    localparam logic [4:0]       ADDR_DUTY0   = 5'h04;
    localparam logic [CNT_W-1:0] ZERO         = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE          = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PERIOD_RST_V = CNT_W'(PERIOD_RST);

    // Pending (software-visible) registers
    logic [N_CH-1:0]  ctrl_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] duty_r [N_CH];

    // Active copies and the period counter
    logic [CNT_W-1:0] act_period_r;
    logic [CNT_W-1:0] act_duty_r [N_CH];
    logic [CNT_W-1:0] cnt_r;

    logic             wrap_flag_r;
    logic [31:0]      d_out_r;
    logic [N_CH-1:0]  pwm_r;

    logic [4:0]       reg_sel_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [CNT_W-1:0] wdata_s;
    logic             idle_s;
    logic             wrap_s;
    logic [N_CH-1:0]  duty_wr_s;
    logic [N_CH-1:0]  pwm_next_s;
    logic [31:0]      rdata_s;
    logic [CNT_W-1:0] fade_step_s;
    logic [CNT_W-1:0] act_duty_next_s [N_CH];
    logic             unused_s;

    assign reg_sel_s = addr[4:0];
    assign wr_en_s   = cs && wr;
    assign rd_en_s   = cs && rd;
    assign wdata_s   = d_in[CNT_W-1:0];

    // Only the low address bits and the low data bits carry meaning.
    assign unused_s  = ^{addr[31:5], d_in[31:CNT_W]};

    // A zero period parks the block: the counter stays at 0 and no wrap occurs.
    assign idle_s    = (act_period_r == ZERO);
    assign wrap_s    = !idle_s && (cnt_r == (act_period_r - ONE));

`ifdef PERIP_PWM_FADE_EN
    logic [CNT_W-1:0] fade_step_r;

    // Move cur toward tgt by at most step and never overshoot. A step of 0 jumps straight to tgt.
    function automatic logic [CNT_W-1:0] fade_next(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt,
                                                   input logic [CNT_W-1:0] step);
        logic [CNT_W-1:0] res;
        if (step == ZERO) begin
            res = tgt;
        end else if (tgt > cur) begin
            res = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > step) ? (cur - step) : tgt;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Fade step register, present only in fade builds.
    always_ff @(posedge clk) begin
        if (reset) begin
            fade_step_r <= ZERO;
        end else if (wr_en_s && (reg_sel_s == ADDR_FADE)) begin
            fade_step_r <= wdata_s;
        end
    end

    assign fade_step_s = fade_step_r;
`else
    assign fade_step_s = ZERO;
`endif

    // Decode the per-channel duty write enables; unused DUTY slots match nothing.
    always_comb begin
        duty_wr_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en_s && (reg_sel_s == (ADDR_DUTY0 + 5'(i)))) begin
                duty_wr_s[i] = 1'b1;
            end else begin
                duty_wr_s[i] = 1'b0;
            end
        end
    end

    // Duty value each channel adopts at the next wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef PERIP_PWM_FADE_EN
            act_duty_next_s[i] = fade_next(act_duty_r[i], duty_r[i], fade_step_s);
`else
            act_duty_next_s[i] = duty_r[i];
`endif
        end
    end

    // Compare stage: the registered pwm output lags cnt by one cycle.
    always_comb begin
        pwm_next_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (ctrl_r[i] && !idle_s && (cnt_r < act_duty_r[i])) begin
                pwm_next_s[i] = 1'b1;
            end else begin
                pwm_next_s[i] = 1'b0;
            end
        end
    end

    // Read multiplexer: zero-extended register contents, 0 for unmapped addresses.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_sel_s)
            ADDR_CTRL:   rdata_s = 32'(ctrl_r);
            ADDR_PERIOD: rdata_s = 32'(period_r);
            ADDR_STATUS: rdata_s = {31'h0000_0000, wrap_flag_r};
            ADDR_FADE:   rdata_s = 32'(fade_step_s);
            default: begin
                rdata_s = 32'h0000_0000;
                for (int i = 0; i < N_CH; i++) begin
                    if (reg_sel_s == (ADDR_DUTY0 + 5'(i))) begin
                        rdata_s = 32'(duty_r[i]);
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // Pending register file written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r   <= {N_CH{1'b0}};
            period_r <= PERIOD_RST_V;
            for (int i = 0; i < N_CH; i++) begin
                duty_r[i] <= ZERO;
            end
        end else begin
            if (wr_en_s && (reg_sel_s == ADDR_CTRL)) begin
                ctrl_r <= d_in[N_CH-1:0];
            end
            if (wr_en_s && (reg_sel_s == ADDR_PERIOD)) begin
                period_r <= wdata_s;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (duty_wr_s[i]) begin
                    duty_r[i] <= wdata_s;
                end
            end
        end
    end

    // Period counter. Active period and duties reload only at the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= ZERO;
            act_period_r <= PERIOD_RST_V;
            for (int i = 0; i < N_CH; i++) begin
                act_duty_r[i] <= ZERO;
            end
        end else if (idle_s) begin
            // While parked there is no wrap to wait for, so a PERIOD write takes effect at once.
            cnt_r <= ZERO;
            if (wr_en_s && (reg_sel_s == ADDR_PERIOD)) begin
                act_period_r <= wdata_s;
            end
        end else if (wrap_s) begin
            cnt_r        <= ZERO;
            act_period_r <= period_r;
            for (int i = 0; i < N_CH; i++) begin
                act_duty_r[i] <= act_duty_next_s[i];
            end
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    // Wrap flag: set on each wrap and cleared by a STATUS read. A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_flag_r <= 1'b0;
        end else if (wrap_s) begin
            wrap_flag_r <= 1'b1;
        end else if (rd_en_s && (reg_sel_s == ADDR_STATUS)) begin
            wrap_flag_r <= 1'b0;
        end
    end

    // Read data register: updated only by a read, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_r <= 32'h0000_0000;
        end else if (rd_en_s) begin
            d_out_r <= rdata_s;
        end
    end

    // PWM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_r <= {N_CH{1'b0}};
        end else begin
            pwm_r <= pwm_next_s;
        end
    end

    assign d_out = d_out_r;
    assign pwm   = pwm_r;

endmodule

// File: tb/tb_perip_pwm_multi.sv
// Self-checking bench for perip_pwm_multi. It drives random and directed bus
// traffic and keeps a period/position model of the PWM in the bench.
module tb_perip_pwm_multi;

    localparam int N_CH       = 4;
    localparam int CNT_W      = 16;
    localparam int PERIOD_RST = 1000;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     d_in;
    logic            cs;
    logic [31:0]     addr;
    logic            rd;
    logic            wr;
    logic [31:0]     d_out;
    logic [N_CH-1:0] pwm;

    int n_pass = 0;
    int n_total = 0;

    perip_pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out), .pwm(pwm)
    );

    always #5 clk = ~clk;

    // Reference model: pending values, active values, position within the period.
    logic [N_CH-1:0] m_ctrl;
    logic [N_CH-1:0] m_pwm;
    logic [31:0]     m_dout;
    int              m_period, m_act_period, m_pos, m_fade, m_wraps, m_mism;
    int              m_duty [N_CH];
    int              m_act_duty [N_CH];
    bit              m_flag;

    function automatic int fade_to(input int act, input int tgt, input int step);
        if (step == 0) return tgt;
        if (tgt > act) return ((tgt - act) > step) ? act + step : tgt;
        return ((act - tgt) > step) ? act - step : tgt;
    endfunction

    function automatic logic [31:0] model_read(input int sel);
        if (sel == 0) return 32'(m_ctrl);
        if (sel == 1) return 32'(m_period);
        if (sel == 2) return {31'd0, m_flag};
        if (sel == 3) return 32'(m_fade);
        if (sel >= 4 && sel < 4 + N_CH) return 32'(m_duty[sel - 4]);
        return 32'd0;
    endfunction

    task automatic m_reset_state();
        m_ctrl = '0; m_pwm = '0; m_dout = 32'd0;
        m_period = PERIOD_RST; m_act_period = PERIOD_RST; m_pos = 0; m_fade = 0;
        m_flag = 1'b0;
        for (int i = 0; i < N_CH; i++) begin m_duty[i] = 0; m_act_duty[i] = 0; end
    endtask

    // One clock: drive the bus, advance the model across the edge, sample 1 time unit later.
    task automatic tick(input bit c, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int sel; int wv; bit wrap; logic [N_CH-1:0] nxt;
        cs = c; rd = r; wr = w; addr = a; d_in = d;
        @(posedge clk);
        sel = int'(a[4:0]);
        wv  = int'(d[CNT_W-1:0]);
        if (reset) begin
            m_reset_state();
        end else begin
            for (int i = 0; i < N_CH; i++)
                nxt[i] = m_ctrl[i] && (m_act_period != 0) && (m_pos < m_act_duty[i]);
            wrap = (m_act_period != 0) && (m_pos == m_act_period - 1);
            if (c && r) m_dout = model_read(sel);
            if (m_act_period == 0) begin
                m_pos = 0;
                if (c && w && sel == 1) m_act_period = wv;
            end else if (wrap) begin
                m_pos = 0;
                m_act_period = m_period;
                for (int i = 0; i < N_CH; i++) m_act_duty[i] = fade_to(m_act_duty[i], m_duty[i], m_fade);
                m_wraps++;
            end else begin
                m_pos++;
            end
            if (wrap) m_flag = 1'b1;
            else if (c && r && sel == 2) m_flag = 1'b0;
            if (c && w) begin
                if (sel == 0) m_ctrl = d[N_CH-1:0];
                else if (sel == 1) m_period = wv;
`ifdef PERIP_PWM_FADE_EN
                else if (sel == 3) m_fade = wv;
`endif
                else if (sel >= 4 && sel < 4 + N_CH) m_duty[sel - 4] = wv;
            end
            m_pwm = nxt;
        end
        #1;
        if ((pwm !== m_pwm) || (d_out !== m_dout)) m_mism++;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wreg(input logic [31:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rreg(input logic [31:0] a);
        tick(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    // Advance until a wrap has happened and the first sample of the new period is visible.
    task automatic wait_start(output bit ok);
        int w0;
        ok = 1'b0;
        w0 = m_wraps;
        for (int k = 0; k < 3000; k++) begin
            if (!ok) begin
                idle(1);
                if ((m_wraps != w0) && (m_pos == 1)) ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        m_mism = 0; m_wraps = 0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        n_total++; if (pwm !== 4'b0000) $display("FAIL reset_pwm got %b want 0000", pwm); else n_pass++;
        n_total++; if (d_out !== 32'd0) $display("FAIL reset_dout got %0d want 0", d_out); else n_pass++;
        rreg(32'h1);
        n_total++; if (d_out !== 32'd1000) $display("FAIL reset_period got %0d want 1000", d_out); else n_pass++;
        wreg(32'h8, 32'd55);
        rreg(32'h8);
        n_total++; if (d_out !== 32'd0) $display("FAIL unused_duty got %0d want 0", d_out); else n_pass++;
        rreg(32'h4);
        n_total++; if (d_out !== 32'd0) $display("FAIL reset_duty0 got %0d want 0", d_out); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL reset_model got %0d want 0 mismatching cycles", m_mism); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok; int bad;
        m_mism = 0; bad = 0;
        wreg(32'h1, 32'd10);
        wreg(32'h4, 32'd3);
        wreg(32'h0, 32'd1);
        rreg(32'h1);
        n_total++; if (d_out !== 32'd10) $display("FAIL period_pending got %0d want 10", d_out); else n_pass++;
        wait_start(ok);
        n_total++; if (!ok) $display("FAIL basic_wrap_timeout got 0 want 1"); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            if (pwm[0] !== ((k % 10) < 3)) bad++;
            idle(1);
        end
        n_total++; if (bad !== 0) $display("FAIL basic_3_of_10 got %0d want 0 bad cycles", bad); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL basic_model got %0d want 0", m_mism); else n_pass++;
    endtask

    task automatic test_edges();
        bit ok; int bad;
        m_mism = 0; bad = 0;
        wreg(32'h5, 32'd0);
        wreg(32'h6, 32'd15);
        wreg(32'h0, 32'h6);
        wait_start(ok);
        n_total++; if (!ok) $display("FAIL edges_wrap_timeout got 0 want 1"); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            if (pwm !== 4'b0100) bad++;
            idle(1);
        end
        n_total++; if (bad !== 0) $display("FAIL duty0_and_over got %0d want 0 bad cycles", bad); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL edges_model got %0d want 0", m_mism); else n_pass++;
    endtask

    task automatic test_ctrl_clear();
        m_mism = 0;
        wreg(32'h0, 32'h1);
        idle(1);
        n_total++; if (pwm[2] !== 1'b0) $display("FAIL ctrl_clear got %b want 0", pwm[2]); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL ctrl_clear_model got %0d want 0", m_mism); else n_pass++;
    endtask

    task automatic test_midperiod();
        bit ok; logic [9:0] v1; logic [9:0] v2;
        m_mism = 0;
        wait_start(ok);
        for (int k = 0; k < 10; k++) begin
            v1[k] = pwm[0];
            if (m_pos == 5) wreg(32'h4, 32'd8); else idle(1);
        end
        for (int k = 0; k < 10; k++) begin
            v2[k] = pwm[0];
            idle(1);
        end
        n_total++; if (v1 !== 10'b0000000111) $display("FAIL mid_current got %b want 0000000111", v1); else n_pass++;
        n_total++; if (v2 !== 10'b0011111111) $display("FAIL mid_next got %b want 0011111111", v2); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL mid_model got %0d want 0", m_mism); else n_pass++;
    endtask

    task automatic test_status();
        bit ok;
        m_mism = 0;
        wait_start(ok);
        rreg(32'h2);
        n_total++; if (d_out !== 32'd1) $display("FAIL status_set got %0d want 1", d_out); else n_pass++;
        rreg(32'h2);
        n_total++; if (d_out !== 32'd0) $display("FAIL status_reread got %0d want 0", d_out); else n_pass++;
        for (int k = 0; k < 20; k++) if (m_pos != 9) idle(1);
        rreg(32'h2);
        n_total++; if (d_out !== 32'd0) $display("FAIL status_at_wrap got %0d want 0", d_out); else n_pass++;
        rreg(32'h2);
        n_total++; if (d_out !== 32'd1) $display("FAIL status_set_wins got %0d want 1", d_out); else n_pass++;
    endtask

    task automatic test_period_zero();
        bit ok; int hi; logic [9:0] v;
        m_mism = 0; hi = 0;
        wreg(32'h1, 32'd0);
        for (int k = 0; k < 30; k++) if (m_act_period != 0) idle(1);
        rreg(32'h2);
        for (int k = 0; k < 15; k++) begin
            if (pwm !== 4'b0000) hi++;
            idle(1);
        end
        n_total++; if (hi !== 0) $display("FAIL idle_pwm got %0d want 0 high cycles", hi); else n_pass++;
        rreg(32'h2);
        n_total++; if (d_out !== 32'd0) $display("FAIL idle_no_wrap got %0d want 0", d_out); else n_pass++;
        wreg(32'h1, 32'd10);
        wait_start(ok);
        for (int k = 0; k < 10; k++) begin v[k] = pwm[0]; idle(1); end
        n_total++; if (v !== 10'b0011111111) $display("FAIL idle_resume got %b want 0011111111", v); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL idle_model got %0d want 0", m_mism); else n_pass++;
    endtask

    task automatic test_fade();
`ifdef PERIP_PWM_FADE_EN
        bit ok; logic [9:0] v [3];
        m_mism = 0;
        wreg(32'h3, 32'd0);
        wreg(32'h4, 32'd0);
        wait_start(ok);
        wreg(32'h3, 32'd2);
        wreg(32'h4, 32'd5);
        rreg(32'h3);
        n_total++; if (d_out !== 32'd2) $display("FAIL fade_read got %0d want 2", d_out); else n_pass++;
        wait_start(ok);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 10; k++) begin v[p][k] = pwm[0]; idle(1); end
        n_total++; if (v[0] !== 10'b0000000011) $display("FAIL fade_step1 got %b want 0000000011", v[0]); else n_pass++;
        n_total++; if (v[1] !== 10'b0000001111) $display("FAIL fade_step2 got %b want 0000001111", v[1]); else n_pass++;
        n_total++; if (v[2] !== 10'b0000011111) $display("FAIL fade_step3 got %b want 0000011111", v[2]); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL fade_model got %0d want 0", m_mism); else n_pass++;
`else
        wreg(32'h3, 32'd7);
        rreg(32'h3);
        n_total++; if (d_out !== 32'd0) $display("FAIL fade_absent got %0d want 0", d_out); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int op; logic [31:0] a; logic [31:0] d;
        m_mism = 0;
        for (int k = 0; k < 3000; k++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 15));
            d  = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 25));
            if (op < 2) wreg(a, d);
            else if (op < 5) rreg(a);
            else idle(1);
        end
        n_total++; if (m_mism !== 0) $display("FAIL random_model got %0d want 0 mismatching cycles", m_mism); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        m_mism = 0;
        wreg(32'h3, 32'd0);
        wreg(32'h1, 32'd10);
        wreg(32'h4, 32'd7);
        wreg(32'h0, 32'h1);
        wait_start(ok);
        wait_start(ok);
        rreg(32'h1);
        for (int k = 0; k < 20; k++) if (m_pos != 6) idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n_total++; if (pwm !== 4'b0000) $display("FAIL rst_mid_pwm got %b want 0000", pwm); else n_pass++;
        n_total++; if (d_out !== 32'd0) $display("FAIL rst_mid_dout got %0d want 0", d_out); else n_pass++;
        idle(999);
        rreg(32'h2);
        n_total++; if (d_out !== 32'd0) $display("FAIL rst_mid_early_wrap got %0d want 0", d_out); else n_pass++;
        rreg(32'h2);
        n_total++; if (d_out !== 32'd1) $display("FAIL rst_mid_wrap_1000 got %0d want 1", d_out); else n_pass++;
        n_total++; if (m_mism !== 0) $display("FAIL rst_mid_model got %0d want 0", m_mism); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; d_in = 32'd0;
        m_reset_state();
        m_wraps = 0; m_mism = 0;
        test_reset();
        test_basic();
        test_edges();
        test_ctrl_clear();
        test_midperiod();
        test_status();
        test_period_zero();
        test_fade();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
